// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_MERGE,
        ST_WR,
        ST_DONE
    } state_t;

    // Encoding 11 is an alias for a full word.
    function automatic logic is_word(input logic [1:0] size);
        return (size == SZ_WORD) || (size == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store merge into the big-endian read word and sub-word load extract/extend.
module lsu_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    input  logic [31:0] rd,
    output logic [31:0] wword,
    output logic [31:0] load_data
);

    always_comb begin
        wword     = wdata;
        load_data = rd;
        if (!is_word(size)) begin
            if (size == SZ_HALF) begin
                wword     = {wdata[15:0], rd[15:0]};
                load_data = {{16{sign_ext & rd[31]}}, rd[31:16]};
            end else begin
                wword     = {wdata[7:0], rd[23:0]};
                load_data = {{24{sign_ext & rd[31]}}, rd[31:24]};
            end
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store controller for a single-port big-endian data memory that always
// writes all four lanes; sub-word stores are done as read-modify-write.
//
// state    | meaning
// IDLE     | ready, waiting for a request
// RD       | address presented, memory read in flight
// MERGE    | read word available: extract load or merge store
// WR       | write strobe asserted with the full word
// DONE     | one-cycle completion pulse
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int SIZE = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req,
    input  logic            req_wr,
    input  logic [1:0]      req_size,
    input  logic            req_signed,
    input  logic [SIZE-1:0] req_addr,
    input  logic [31:0]     req_wdata,
    output logic            ready,
    output logic            done,
    output logic [31:0]     rdata,
    output logic [SIZE-1:0] mem_addr,
    output logic [31:0]     mem_wdata,
    output logic            mem_wr,
    input  logic [31:0]     mem_rdata
);

    state_t          state;
    state_t          state_nxt;
    logic [SIZE-1:0] addr_q;
    logic            wr_q;
    logic [1:0]      size_q;
    logic            sign_q;
    logic [31:0]     wdata_q;
    logic [31:0]     wword_q;
    logic [31:0]     rdata_q;
    logic [31:0]     merged;
    logic [31:0]     load_data;
    logic            accept;

    assign accept = req && (state == ST_IDLE);

    lsu_align u_align (
        .size      (size_q),
        .sign_ext  (sign_q),
        .wdata     (wdata_q),
        .rd        (mem_rdata),
        .wword     (merged),
        .load_data (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            sign_q  <= 1'b0;
            wdata_q <= '0;
            wword_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q  <= req_addr;
                wr_q    <= req_wr;
                size_q  <= req_size;
                sign_q  <= req_signed;
                wdata_q <= req_wdata;
                // Word stores skip the read, so the write word is known now.
                if (req_wr && is_word(req_size)) begin
                    wword_q <= req_wdata;
                end
            end
            if (state == ST_MERGE) begin
                if (wr_q) begin
                    wword_q <= merged;
                end else begin
                    rdata_q <= load_data;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = (req_wr && is_word(req_size)) ? ST_WR : ST_RD;
                end
            end
            ST_RD:    state_nxt = ST_MERGE;
            ST_MERGE: state_nxt = wr_q ? ST_WR : ST_DONE;
            ST_WR:    state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign ready     = (state == ST_IDLE);
    assign done      = (state == ST_DONE);
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wword_q;
    // Gated with reset so an abort can never land a write on the reset edge.
    assign mem_wr    = (state == ST_WR) & rst_n;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit against a 4 KiB big-endian memory model.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        ready;
    logic        done;
    logic [31:0] rdata;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic [31:0] mem_rdata;

    typedef struct {
        logic        is_load;
        logic [31:0] data;
        int          lat;
        int          nwr;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   failed = 0;
    int   acc_cnt = 0;
    int   last_acc = 0;
    int   age = 0;
    int   wr_cnt = 0;
    int   wr_cyc = -1;
    int   wr_total = 0;
    int   done_cnt = 0;

    logic [7:0]  mem [0:4095] = '{default: 8'h00};
    logic [31:0] rd_q = 32'h0;

    mem_access_unit #(.SIZE(12)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_wr     (req_wr),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .ready      (ready),
        .done       (done),
        .rdata      (rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr) begin
            mem[mem_addr]         <= mem_wdata[31:24];
            mem[mem_addr + 12'd1] <= mem_wdata[23:16];
            mem[mem_addr + 12'd2] <= mem_wdata[15:8];
            mem[mem_addr + 12'd3] <= mem_wdata[7:0];
        end
        rd_q <= {mem[mem_addr], mem[mem_addr + 12'd1], mem[mem_addr + 12'd2], mem[mem_addr + 12'd3]};
    end
    assign mem_rdata = rd_q;

    always @(posedge clk) begin
        if (rst_n && req && ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [11:0] a);
        return {mem[a], mem[a + 12'd1], mem[a + 12'd2], mem[a + 12'd3]};
    endfunction

    // Monitor: tracks cycle age since the last accept and checks each done pulse.
    always @(negedge clk) begin
        if (acc_cnt != last_acc) begin
            last_acc = acc_cnt;
            age      = 1;
            wr_cnt   = 0;
            wr_cyc   = -1;
        end else begin
            age++;
        end
        if (mem_wr) begin
            wr_cnt++;
            wr_total++;
            wr_cyc = age;
        end
        if (done) begin
            done_cnt++;
            if (q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL unexpected_done: done seen with no access outstanding (age %0d)", age);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_latency", age, e.lat);
                chk("write_count", wr_cnt, e.nwr);
                if (e.nwr > 0) chk("write_cycle", wr_cyc, e.lat - 1);
                if (e.is_load) chk("load_rdata", rdata, e.data);
            end
        end
    end

    task automatic issue(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [11:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rd, input logic expect_done);
        exp_t e;
        @(negedge clk);
        req        = 1'b1;
        req_wr     = wr;
        req_size   = sz;
        req_signed = sgn;
        req_addr   = a;
        req_wdata  = d;
        if (expect_done) begin
            e.is_load = !wr;
            e.data    = exp_rd;
            e.lat     = !wr ? 3 : (is_word(sz) ? 2 : 4);
            e.nwr     = wr ? 1 : 0;
            q.push_back(e);
        end
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (q.size() == 0 && ready) break;
        end
        if (q.size() != 0) begin
            chk("timeout_pending", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        int          wr_before;
        int          done_before;
        rst_n      = 1'b0;
        req        = 1'b0;
        req_wr     = 1'b0;
        req_size   = SZ_BYTE;
        req_signed = 1'b0;
        req_addr   = 12'h0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wr", mem_wr, 0);
        rst_n = 1'b1;

        issue(1, SZ_WORD, 0, 12'h010, 32'h11223344, 0, 1);
        wait_idle();
        chk("mem_word_store", mem_word(12'h010), 32'h11223344);

        issue(1, SZ_BYTE, 0, 12'h012, 32'hAAAAAA80, 0, 1);
        wait_idle();
        chk("mem_byte_store", mem_word(12'h010), 32'h11228044);

        issue(0, SZ_BYTE, 1, 12'h012, 0, 32'hFFFFFF80, 1);
        wait_idle();
        issue(0, SZ_BYTE, 0, 12'h012, 0, 32'h00000080, 1);
        wait_idle();

        issue(1, SZ_HALF, 0, 12'h013, 32'h1234BEEF, 0, 1);
        wait_idle();
        chk("mem_half_lo", mem_word(12'h010), 32'h112280BE);
        chk("mem_half_hi", mem_word(12'h014), 32'hEF000000);

        issue(0, SZ_HALF, 1, 12'h013, 0, 32'hFFFFBEEF, 1);
        wait_idle();
        issue(0, SZ_HALF, 0, 12'h010, 0, 32'h00001122, 1);
        wait_idle();
        issue(0, SZ_BYTE, 1, 12'h010, 0, 32'h00000011, 1);
        wait_idle();

        issue(1, 2'b11, 0, 12'h030, 32'hCAFEF00D, 0, 1);
        wait_idle();
        issue(0, 2'b11, 1, 12'h030, 0, 32'hCAFEF00D, 1);
        wait_idle();

        issue(1, SZ_WORD, 0, 12'hFFE, 32'hA1B2C3D4, 0, 1);
        wait_idle();
        chk("wrap_bytes", {mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]}, 32'hA1B2C3D4);
        issue(0, SZ_WORD, 0, 12'hFFE, 0, 32'hA1B2C3D4, 1);
        wait_idle();
        issue(1, SZ_WORD, 0, 12'h040, 32'h01020304, 0, 1);
        wait_idle();
        chk("rdata_held", rdata, 32'hA1B2C3D4);

        // Abort a byte store while it sits in MERGE.
        wr_before   = wr_total;
        done_before = done_cnt;
        issue(1, SZ_BYTE, 0, 12'h020, 32'h00000055, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ready", ready, 1);
        chk("abort_done", done, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_write", wr_total - wr_before, 0);
        chk("abort_no_done", done_cnt - done_before, 0);
        chk("abort_mem", mem_word(12'h020), 32'h00000000);

        // Requests during a load's RD/MERGE/DONE must be dropped.
        done_before = done_cnt;
        issue(0, SZ_WORD, 0, 12'h010, 0, 32'h112280BE, 1);
        req        = 1'b1;
        req_wr     = 1'b1;
        req_size   = SZ_WORD;
        req_addr   = 12'h010;
        req_wdata  = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        req = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("busy_one_done", done_cnt - done_before, 1);
        chk("busy_mem_kept", mem_word(12'h010), 32'h112280BE);
        chk("queue_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Initiator-side load/store controller for the multi-cycle CPU. Takes one byte, halfword or word request from the datapath and drives the byte-addressed, big-endian, 4-bank data memory over its single-port interface. It performs read-modify-write for sub-word stores, because the memory writes all four byte lanes on every `mem_wr`. It also extracts and sign- or zero-extends sub-word load data. It sits between the CPU control/datapath and the data memory, and is the only master of the memory ports.

## Interface
Parameters:
- `SIZE`, default 12: byte-address width; memory holds 2^SIZE bytes.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req`  in  1  request valid; accepted on a rising edge where `req && ready`.
- `req_wr`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- `req_signed`  in  1  load sign extension; 0 = zero extension.
- `req_addr`  in  SIZE  byte address; any alignment.
- `req_wdata`  in  32  store data; a byte uses [7:0], a halfword uses [15:0].
- `ready`  out  1  unit idle, can accept a request.
- `done`  out  1  one-cycle pulse: access complete.
- `rdata`  out  32  extended load result; valid while `done` is high and held until the next load completes.
- `mem_addr`  out  SIZE  memory byte address.
- `mem_wdata`  out  32  memory write word; byte at `mem_addr` is in [31:24].
- `mem_wr`  out  1  memory write strobe.
- `mem_rdata`  in  32  memory read word; byte at address a in [31:24], a+1 in [23:16], a+2 in [15:8], a+3 in [7:0].

## Operation
- Memory contract:
  - Synchronous read: the address sampled at edge N gives `mem_rdata` valid after edge N+1.
  - A write happens at any edge where `mem_wr=1`.
  - The memory wraps addresses a+1..a+3 modulo 2^SIZE.
- On accept, latch `req_addr`, `req_wr`, `req_size`, `req_signed` and `req_wdata` into registers. `mem_addr` is driven from the latched address for the whole access.
- FSM states are IDLE, RD, MERGE, WR, DONE. Transitions:
  - IDLE, accept of a word store → WR.
  - IDLE, accept of any other request → RD.
  - RD → MERGE. `mem_wr=0`.
  - MERGE, load: capture `mem_rdata`, extract and extend into `rdata` → DONE.
  - MERGE, store: form the write word → WR.
    - Byte store: {wdata[7:0], rd[23:0]}.
    - Halfword store: {wdata[15:0], rd[15:0]}.
  - WR: `mem_wr=1`, `mem_wdata` = write word → DONE.
  - DONE: `done=1` → IDLE.
- Load extraction:
  - Byte: rd[31:24].
  - Halfword: rd[31:16].
  - Word: rd.
  - Sub-word results are extended to 32 bits per `req_signed`.
- `ready` = 1 only in IDLE. `req` while busy is ignored; nothing is queued.
- `mem_wr` = (state==WR) & `rst_n`. No write occurs at any edge where reset is asserted.

## Timing
- Reset values: state IDLE, `ready=1`, `done=0`, `rdata=0`, `mem_addr=0`, `mem_wdata=0`, `mem_wr=0`.
- Cycle numbering: the accept edge ends cycle 0.
- Word store: WR in cycle 1, `done` in cycle 2.
- Load: RD in cycle 1, MERGE in cycle 2, `done` in cycle 3.
- Sub-word store: RD in cycle 1, MERGE in cycle 2, WR in cycle 3, `done` in cycle 4.
- Minimum accept spacing:
  - Word store: 3 cycles.
  - Load: 4 cycles.
  - Sub-word store: 5 cycles.
- `rst_n` low at any edge forces IDLE at that edge.
  - No partial write ever occurs; the memory image is unchanged.
  - `done` is not pulsed for the aborted access.
- No width overflow: the address is never incremented by this unit; wrap is the memory's responsibility.

## Structure
- Package `mem_access_pkg`:
  - Size encodings: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - FSM state enum.
- Sub-module `lsu_align`: combinational store merge and load extract/extend. Inputs are size, signed flag, wdata and rd; outputs are the write word and the load result. The FSM and registers stay in the top.

## Test plan
The bench uses a behavioural 4096-byte big-endian memory with 1-cycle read latency.
- Word store, addr 0x010, data 0x11223344 → `mem_wr` high only in cycle 1; bytes 0x010..0x013 = 11 22 33 44; `done` in cycle 2.
- Byte store 0x80 at 0x012:
  - Memory becomes 11 22 80 44.
  - Signed byte load at 0x012 → `rdata`=0xFFFFFF80.
  - Unsigned byte load at 0x012 → 0x00000080.
  - `done` in cycle 3 for each load.
- Unaligned halfword store 0xBEEF at 0x013:
  - Bytes 0x013 = BE, 0x014 = EF; 0x010..0x012 and 0x015..0x016 are unchanged.
  - Signed halfword load at 0x013 → 0xFFFFBEEF.
- Wrap: word store 0xA1B2C3D4 at 0xFFE → bytes FFE=A1, FFF=B2, 000=C3, 001=D4; word load at 0xFFE → 0xA1B2C3D4.
- `rst_n` low during MERGE of a byte store → `mem_wr` never high; memory unchanged; `ready=1` and `done=0` after the edge.
- `req` pulsed with different data while a load is in RD/MERGE → ignored; only the first access completes; one `done` pulse.
